// File: rtl/mul_pkg.sv
// Shared types and constants for the iterative multiplier and the register file.
package mul_pkg;
    localparam int MUL_WIDTH  = 64;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;
endpackage

// File: rtl/mul_iter_if.sv
// Operand/result bundle between the register file ports and mul_iter.
// result_hi exists only when MUL_HIGH_EN is defined.
interface mul_iter_if #(parameter int WIDTH = mul_pkg::MUL_WIDTH);
    import mul_pkg::*;

    logic                  start;
    logic [WIDTH-1:0]      a;
    logic [WIDTH-1:0]      b;
    logic [REG_ADDR_W-1:0] dest;
    logic                  busy;
    logic                  done;
    logic [WIDTH-1:0]      result;
    logic [REG_ADDR_W-1:0] result_reg;
`ifdef MUL_HIGH_EN
    logic [WIDTH-1:0]      result_hi;

    modport master (output start, a, b, dest,
                    input  busy, done, result, result_reg, result_hi);
    modport slave  (input  start, a, b, dest,
                    output busy, done, result, result_reg, result_hi);
`else
    modport master (output start, a, b, dest,
                    input  busy, done, result, result_reg);
    modport slave  (input  start, a, b, dest,
                    output busy, done, result, result_reg);
`endif
endinterface

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier (MUL); WIDTH steps, result with a one-cycle done strobe.
// Define MUL_HIGH_EN to widen the datapath and also produce the unsigned high half (UMULH).
module mul_iter
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic     clk,
    input  logic     reset_n,
    mul_iter_if.slave bus
);

`ifdef MUL_HIGH_EN
    localparam int AW = 2 * WIDTH;
`else
    localparam int AW = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH);

    mul_state_t            state;
    logic [AW-1:0]         acc;
    logic [AW-1:0]         mcand;
    logic [WIDTH-1:0]      mplier;
    logic [CW-1:0]         cnt;
    logic [REG_ADDR_W-1:0] dest_q;
    logic                  busy_q;
    logic                  done_q;
    logic [WIDTH-1:0]      result_q;
    logic [REG_ADDR_W-1:0] result_reg_q;
    logic [AW-1:0]         acc_nxt;

    assign acc_nxt = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            cnt          <= '0;
            dest_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
            result_reg_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                // DONE accepts a new start just like IDLE for back-to-back issue
                IDLE, DONE: begin
                    if (bus.start) begin
                        mcand  <= AW'(bus.a);
                        mplier <= bus.b;
                        dest_q <= bus.dest;
                        acc    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        result_q     <= acc_nxt[WIDTH-1:0];
                        result_reg_q <= dest_q;
                        done_q       <= 1'b1;
                        busy_q       <= 1'b0;
                        state        <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MUL_HIGH_EN
    logic [WIDTH-1:0] result_hi_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            result_hi_q <= '0;
        else if (state == RUN && cnt == CW'(WIDTH - 1))
            result_hi_q <= acc_nxt[AW-1:WIDTH];
    end

    assign bus.result_hi = result_hi_q;
`endif

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.result     = result_q;
    assign bus.result_reg = result_reg_q;

endmodule

// File: tb/tb_mul_iter.sv
// Directed table-driven bench for mul_iter plus hand sequences for ignore/reset/back-to-back cases.
module tb_mul_iter;
    import mul_pkg::*;

    logic clk;
    logic reset_n;
    int   n_chk;
    int   n_fail;

    mul_iter_if #(.WIDTH(64)) bus ();

    mul_iter #(.WIDTH(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  dest;
        logic [63:0] lo;
        logic [63:0] hi;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Wait (bounded) for done; counts edges and busy cycles along the way.
    task automatic wait_done(output int edges, output int bcnt);
        edges = 0;
        bcnt  = 0;
        while (bus.done !== 1'b1 && edges < 200) begin
            if (bus.busy === 1'b1) bcnt++;
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic launch(input logic [63:0] a, input logic [63:0] b, input logic [4:0] d);
        bus.a     = a;
        bus.b     = b;
        bus.dest  = d;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, " busy"},       128'(bus.busy),       128'd0);
        chk({tag, " done"},       128'(bus.done),       128'd0);
        chk({tag, " result"},     128'(bus.result),     128'd0);
        chk({tag, " result_reg"}, 128'(bus.result_reg), 128'd0);
`ifdef MUL_HIGH_EN
        chk({tag, " result_hi"},  128'(bus.result_hi),  128'd0);
`endif
    endtask

    initial begin
        int edges;
        int bcnt;
        int edges2;
        int dcnt;

        n_chk  = 0;
        n_fail = 0;

        vecs[0] = '{a: 64'd3, b: 64'd5, dest: 5'd7, lo: 64'd15, hi: 64'd0};
        vecs[1] = '{a: 64'hFFFF_FFFF_FFFF_FFFF, b: 64'd2, dest: 5'd3,
                    lo: 64'hFFFF_FFFF_FFFF_FFFE, hi: 64'd1};
        vecs[2] = '{a: 64'd0, b: 64'hDEAD, dest: 5'd12, lo: 64'd0, hi: 64'd0};
        vecs[3] = '{a: 64'd6, b: 64'd7, dest: 5'd31, lo: 64'd42, hi: 64'd0};
        vecs[4] = '{a: 64'h0000_0001_0000_0001, b: 64'h0000_0001_0000_0001, dest: 5'd1,
                    lo: 64'h0000_0002_0000_0001, hi: 64'd1};
        vecs[5] = '{a: 64'h8000_0000_0000_0000, b: 64'd3, dest: 5'd20,
                    lo: 64'h8000_0000_0000_0000, hi: 64'd1};

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.dest  = '0;
        reset_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].dest);
            wait_done(edges, bcnt);
            chk($sformatf("v%0d latency", i), 128'(edges + 1), 128'd65);
            chk($sformatf("v%0d busy_cycles", i), 128'(bcnt), 128'd64);
            chk($sformatf("v%0d busy_at_done", i), 128'(bus.busy), 128'd0);
            chk($sformatf("v%0d result", i), 128'(bus.result), 128'(vecs[i].lo));
            chk($sformatf("v%0d result_reg", i), 128'(bus.result_reg), 128'(vecs[i].dest));
`ifdef MUL_HIGH_EN
            chk($sformatf("v%0d result_hi", i), 128'(bus.result_hi), 128'(vecs[i].hi));
`endif
            @(posedge clk);
            #1;
            chk($sformatf("v%0d done_one_cycle", i), 128'(bus.done), 128'd0);
            chk($sformatf("v%0d result_held", i), 128'(bus.result), 128'(vecs[i].lo));
        end

        // start during RUN must be ignored
        launch(64'd100, 64'd200, 5'd9);
        repeat (9) @(posedge clk);
        #1;
        bus.a     = 64'd9;
        bus.b     = 64'd9;
        bus.dest  = 5'd2;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(edges, bcnt);
        chk("ignore latency", 128'(edges + 11), 128'd65);
        chk("ignore result", 128'(bus.result), 128'd20000);
        chk("ignore result_reg", 128'(bus.result_reg), 128'd9);
        dcnt = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dcnt++;
        end
        chk("ignore extra_done", 128'(dcnt), 128'd0);

        // asynchronous reset mid-RUN drops the operation
        launch(64'd1000, 64'd1000, 5'd11);
        repeat (29) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        #10;
        reset_n = 1'b1;
        dcnt = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dcnt++;
        end
        chk("midreset no_done", 128'(dcnt), 128'd0);
        launch(64'd6, 64'd7, 5'd6);
        wait_done(edges, bcnt);
        chk("postreset latency", 128'(edges + 1), 128'd65);
        chk("postreset result", 128'(bus.result), 128'd42);
        chk("postreset result_reg", 128'(bus.result_reg), 128'd6);
        @(posedge clk);
        #1;

        // start held high: back-to-back operations
        bus.a     = 64'd2;
        bus.b     = 64'd3;
        bus.dest  = 5'd4;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.a    = 64'd4;
        bus.b    = 64'd5;
        bus.dest = 5'd5;
        wait_done(edges, bcnt);
        chk("b2b first cycle", 128'(edges + 1), 128'd65);
        chk("b2b first result", 128'(bus.result), 128'd6);
        chk("b2b first result_reg", 128'(bus.result_reg), 128'd4);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("b2b restart busy", 128'(bus.busy), 128'd1);
        wait_done(edges2, bcnt);
        chk("b2b second cycle", 128'(edges + 1 + edges2 + 1), 128'd130);
        chk("b2b second result", 128'(bus.result), 128'd20);
        chk("b2b second result_reg", 128'(bus.result_reg), 128'd5);
        @(posedge clk);
        #1;
        chk("b2b idle done", 128'(bus.done), 128'd0);
        chk("b2b idle busy", 128'(bus.busy), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_iter.md
# mul_iter

Iterative shift-add multiplier for the LEGv8 datapath, placed between the register file read ports and its write port. It consumes the two read operands and a destination register number, computes the low 64 bits of the product over a fixed number of cycles, then presents the result with a one-cycle write strobe that drives the register file write port (`WriteData`, `WriteRegister`, `RegWrite`). It implements `MUL`. Under a build option it also implements `UMULH`.

## Interface
Parameters:
- `WIDTH`, default 64: operand and result width.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: request a multiply; sampled at rising edges.
- `a`, input, `WIDTH`: multiplicand (from `ReadData1`).
- `b`, input, `WIDTH`: multiplier (from `ReadData2`).
- `dest`, input, 5: destination register number.
- `busy`, output, 1: high while a multiply is in progress.
- `done`, output, 1: one-cycle completion strobe; drives `RegWrite`.
- `result`, output, `WIDTH`: low half of the product; drives `WriteData`.
- `result_reg`, output, 5: destination latched at start; drives `WriteRegister`.
- `result_hi`, output, `WIDTH`: high half of the product; present only with `MUL_HIGH_EN`.

## Operation
- The state machine has three states: IDLE, RUN, DONE.
  - IDLE: `start`=1 latches `a`, `b` and `dest`, clears the accumulator and the counter, then moves to RUN. `start`=0 stays in IDLE.
  - RUN: one step per edge, in this order:
    1. If the multiplier LSB is 1, add the multiplicand to the accumulator.
    2. Shift the multiplicand left by 1 and the multiplier right by 1.
    3. Increment the counter.
  - RUN exit: on the step where the counter reaches `WIDTH`-1, the final accumulator value is loaded into `result` (and `result_hi`), the latched `dest` is loaded into `result_reg`, and the state moves to DONE.
  - DONE: `done`=1 for exactly one cycle. On the next edge, `start`=1 is accepted exactly as in IDLE (back-to-back operation); otherwise the state returns to IDLE.
- `busy` = (state == RUN).
- `start` in RUN is ignored; the operands are not re-latched.
- Arithmetic:
  - The accumulator is `WIDTH` bits and wraps modulo 2^`WIDTH`; overflow is discarded.
  - The low half is sign-agnostic, so `MUL` needs no signed handling.
  - The counter is `$clog2(WIDTH)` bits.
- Latency is fixed: there is no early termination on zero operands.
- `result` and `result_reg` hold their last values until the next completion. They are qualified only by `done`.
- `dest`=31 is not special-cased here: `done` still fires, and the register file's XZR handling applies.
- Reset (asynchronous, at any time, including mid-RUN):
  - State goes to IDLE.
  - `busy`, `done`, `result`, `result_reg`, `result_hi`, the accumulator and the counter all go to 0.
  - An in-flight operation is dropped with no `done`.

## Timing
- Let E0 be the edge that samples `start`=1 in IDLE or DONE.
  - RUN occupies edges E0+1 through E0+`WIDTH`.
  - `busy`=1 in the cycles following edges E0 through E0+`WIDTH`-1.
  - `done`=1 in the cycle following edge E0+`WIDTH`, with `result` and `result_reg` valid in that same cycle.
- Latency from start to done is `WIDTH`+1 cycles, which is 65 for the default width.
- Throughput is one operation per `WIDTH`+1 cycles when `start` is held or re-asserted during DONE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `MUL_HIGH_EN`.
- Defined:
  - The accumulator and multiplicand are 2×`WIDTH` bits.
  - `result_hi` carries bits [2`WIDTH`-1:`WIDTH`] of the unsigned product (`UMULH`).
  - The port and its registers reset to 0.
  - The low half is unchanged.
- Undefined:
  - The `result_hi` port and the high-half registers are absent.
  - The accumulator and multiplicand are `WIDTH` bits.

## Structure
- Shared package `mul_pkg`:
  - `mul_state_t` enum {IDLE, RUN, DONE}.
  - `MUL_WIDTH` = 64, used as the `WIDTH` default.
  - `REG_ADDR_W` = 5, shared with the register file.
- Single module. The shift-add step is small enough to stay inline; no sub-module is required.

## Test plan
- Reset, then `a`=3, `b`=5, `dest`=7, `start` for one cycle -> `busy` for 64 cycles; `done`=1 exactly once at cycle 65; `result`=15; `result_reg`=7.
- `a`=0xFFFF_FFFF_FFFF_FFFF, `b`=2 -> `result`=0xFFFF_FFFF_FFFF_FFFE. With `MUL_HIGH_EN`, `result_hi`=1.
- `start` pulsed at cycle 10 of RUN with `a`=9, `b`=9 -> ignored; the original result completes unchanged; only one `done`.
- Assert `reset_n`=0 asynchronously mid-RUN (cycle 30) -> all outputs 0 immediately; no `done` follows; a fresh 6×7 then yields 42.
- `start` held high, operand pairs (2,3) then (4,5) -> `done` at cycles 65 and 130 with `result` 6 and 20.
- `a`=0, `b`=0xDEAD -> latency still 65 cycles; `result`=0; `result_reg` = latched `dest`.
